// File: rtl/frame_sched_pkg.sv
// rtl/frame_sched_pkg.sv - frame_sched state encoding and default frame geometry
package frame_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ZERO    = 3'd1,
    ST_SYNC    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_GAP     = 3'd4
  } state_t;

  localparam int DEF_ZERO_LEN = 32;
  localparam int DEF_SYNC_LEN = 8;
  localparam int DEF_SEQ_LEN  = 8;

endpackage

// File: rtl/frame_sched_bitcnt.sv
// rtl/frame_sched_bitcnt.sv - loadable strobe-gated down-counter shared by all frame phases
module frame_sched_bitcnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  // Loaded with length-1, so tc marks the last strobe of a phase.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/frame_sched.sv
// rtl/frame_sched.sv - serial frame scheduler: zero preamble, sync, payload, gap
// Optional FRAME_SCHED_AUTO_REPEAT_EN: restart the next frame from GAP exit until abort.
module frame_sched
  import frame_sched_pkg::*;
#(
  parameter int ZERO_LEN = DEF_ZERO_LEN,
  parameter int SYNC_LEN = DEF_SYNC_LEN,
  parameter int SEQ_LEN  = DEF_SEQ_LEN,
  parameter int CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               bit_en,
  input  logic [CNT_W-1:0]   payload_len,
  input  logic [7:0]         gap_len,
  input  logic               src_valid,
  input  logic               src_bit,
  output logic               src_ready,
  output logic               data_out,
  output logic [2:0]         phase,
  output logic               busy,
  output logic               frame_done,
  output logic [CNT_W-1:0]   frame_cnt,
  output logic [SEQ_LEN-1:0] first_sequence,
  output logic [7:0]         underrun_cnt
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   plen_q;
  logic [7:0]         gap_q;
  logic [CNT_W-1:0]   cnt, cnt_load_val, pay_idx;
  logic               cnt_tc, cnt_clr, cnt_load, cnt_en;
  logic               data_d, done_d, latch_len, under_inc, frame_end;
  logic [SEQ_LEN-1:0] seq_d;

  frame_sched_bitcnt #(.W(CNT_W)) u_bitcnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .cnt      (cnt),
    .tc       (cnt_tc)
  );

  // Counter runs down during PAYLOAD, so the payload bit index is recovered from it.
  assign pay_idx   = plen_q - cnt - CNT_W'(1);
  assign src_ready = (state_q == ST_PAYLOAD) && bit_en;
  assign busy      = (state_q != ST_IDLE);
  assign phase     = state_q;

  always_comb begin
    state_d      = state_q;
    cnt_clr      = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    data_d       = data_out;
    done_d       = 1'b0;
    latch_len    = 1'b0;
    under_inc    = 1'b0;
    frame_end    = 1'b0;
    seq_d        = first_sequence;

    case (state_q)
      ST_IDLE: begin
        data_d = 1'b0;
        if (start) begin
          state_d      = ST_ZERO;
          cnt_load     = 1'b1;
          cnt_load_val = CNT_W'(ZERO_LEN - 1);
          latch_len    = 1'b1;
          seq_d        = '0;
        end
      end
      ST_ZERO: begin
        if (bit_en) begin
          data_d = 1'b0;
          if (cnt_tc) begin
            state_d      = ST_SYNC;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(SYNC_LEN - 1);
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      ST_SYNC: begin
        if (bit_en) begin
          data_d = 1'b1;
          if (!cnt_tc) begin
            cnt_en = 1'b1;
          end else if (plen_q != '0) begin
            state_d      = ST_PAYLOAD;
            cnt_load     = 1'b1;
            cnt_load_val = plen_q - CNT_W'(1);
          end else if (gap_q != 8'd0) begin
            state_d      = ST_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(gap_q) - CNT_W'(1);
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      ST_PAYLOAD: begin
        if (bit_en) begin
          data_d    = src_valid & src_bit;
          under_inc = ~src_valid;
          for (int i = 0; i < SEQ_LEN; i++) begin
            if (pay_idx == CNT_W'(SEQ_LEN - 1 - i)) seq_d[i] = data_d;
          end
          if (!cnt_tc) begin
            cnt_en = 1'b1;
          end else if (gap_q != 8'd0) begin
            state_d      = ST_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(gap_q) - CNT_W'(1);
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (bit_en) begin
          data_d = 1'b0;
          if (cnt_tc) frame_end = 1'b1;
          else        cnt_en    = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (frame_end) begin
      done_d = 1'b1;
`ifdef FRAME_SCHED_AUTO_REPEAT_EN
      state_d      = ST_ZERO;
      cnt_load     = 1'b1;
      cnt_load_val = CNT_W'(ZERO_LEN - 1);
      seq_d        = '0;
`else
      state_d = ST_IDLE;
`endif
    end

    // Abort overrides everything, including a start seen in the same cycle.
    if (abort) begin
      state_d   = ST_IDLE;
      cnt_clr   = 1'b1;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      data_d    = 1'b0;
      done_d    = 1'b0;
      latch_len = 1'b0;
      under_inc = 1'b0;
      seq_d     = first_sequence;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      plen_q         <= '0;
      gap_q          <= '0;
      data_out       <= 1'b0;
      frame_done     <= 1'b0;
      frame_cnt      <= '0;
      first_sequence <= '0;
      underrun_cnt   <= '0;
    end else begin
      state_q        <= state_d;
      data_out       <= data_d;
      frame_done     <= done_d;
      first_sequence <= seq_d;
      if (latch_len) begin
        plen_q <= payload_len;
        gap_q  <= gap_len;
      end
      if (done_d) frame_cnt <= frame_cnt + CNT_W'(1);
      if (under_inc && underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_frame_sched.sv
// tb/tb_frame_sched.sv - scoreboard bench for frame_sched
module tb_frame_sched;

  logic        clk, reset, start, abort, bit_en;
  logic [15:0] payload_len;
  logic [7:0]  gap_len;
  logic        src_valid, src_bit;
  logic        src_ready, data_out, busy, frame_done;
  logic [2:0]  phase;
  logic [15:0] frame_cnt;
  logic [7:0]  first_sequence, underrun_cnt;

  frame_sched dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .abort          (abort),
    .bit_en         (bit_en),
    .payload_len    (payload_len),
    .gap_len        (gap_len),
    .src_valid      (src_valid),
    .src_bit        (src_bit),
    .src_ready      (src_ready),
    .data_out       (data_out),
    .phase          (phase),
    .busy           (busy),
    .frame_done     (frame_done),
    .frame_cnt      (frame_cnt),
    .first_sequence (first_sequence),
    .underrun_cnt   (underrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   done_cnt = 0;
  logic exp_q[$];
  logic pend = 1'b0;
  logic hold_chk = 1'b0;
  logic last_bit = 1'b0;
  logic mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a strobe seen at one negedge produces the bit checked at the next.
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (pend) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("data_out", data_out, mon_e);
        last_bit = mon_e;
      end
      pend = 1'b0;
    end else if (hold_chk && busy) begin
      check("data_out_hold", data_out, last_bit);
    end
    if (bit_en && busy && !abort) pend = 1'b1;
  end

  task automatic run_frame(input bit do_start, input int plen, input int gap, input int period,
                           input logic [15:0] bits, input logic [15:0] valid, input int abort_at);
    int tot;
    int k;
    logic e;
    tot = 40 + plen + gap;
    if (do_start) begin
      payload_len = 16'(plen);
      gap_len     = 8'(gap);
      start       = 1'b1;
      @(posedge clk); #1;
      check("start_phase", phase, 1);
      // Later length changes and repeated start must not disturb the frame.
      payload_len = ~payload_len;
      gap_len     = ~gap_len;
    end
    for (int i = 1; i <= tot; i++) begin
      src_valid = 1'b1;
      src_bit   = 1'b0;
      if (i <= 32)             e = 1'b0;
      else if (i <= 40)        e = 1'b1;
      else if (i <= 40 + plen) begin
        k = i - 41;
        src_valid = valid[k];
        src_bit   = bits[k];
        e = valid[k] & bits[k];
      end else                 e = 1'b0;
      start  = (i < tot);
      bit_en = 1'b1;
      if (i == abort_at) abort = 1'b1;
      else               exp_q.push_back(e);
      if (i == 1) begin #1; check("src_ready_zero", src_ready, 0); end
      if (i == 41 && plen > 0) begin #1; check("src_ready_payload", src_ready, 1); end
      @(posedge clk); #1;
      bit_en = 1'b0;
      abort  = 1'b0;
      if (i == abort_at) begin
        start = 1'b0;
        return;
      end
      if (i < tot) repeat (period - 1) begin @(posedge clk); #1; end
    end
    start = 1'b0;
    check("frame_done_pulse", frame_done, 1);
  endtask

  task automatic finish_frame(input int done_before, input int exp_cnt, input logic [7:0] exp_fs);
    repeat (2) @(posedge clk);
    #1;
    check("done_count", done_cnt, done_before + 1);
    check("frame_cnt", frame_cnt, exp_cnt);
    check("first_sequence", first_sequence, exp_fs);
    check("scoreboard_drained", exp_q.size(), 0);
`ifdef FRAME_SCHED_AUTO_REPEAT_EN
    check("repeat_phase", phase, 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_phase", phase, 0);
`else
    check("idle_phase", phase, 0);
    check("idle_data", data_out, 0);
`endif
  endtask

  int d0;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0; bit_en = 1'b0;
    payload_len = '0; gap_len = '0; src_valid = 1'b0; src_bit = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase", phase, 0);
    check("rst_data", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", frame_done, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_seq", first_sequence, 0);
    check("rst_underrun", underrun_cnt, 0);
    check("rst_ready", src_ready, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    // start together with abort stays idle
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_beats_start", phase, 0);

    // abort on strobe 40
    run_frame(1, 16, 4, 1, 16'h5555, 16'hFFFF, 40);
    check("abort_phase", phase, 0);
    check("abort_data", data_out, 0);
    check("abort_busy", busy, 0);
    check("abort_cnt", frame_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", done_cnt, 0);
    check("abort_drained", exp_q.size(), 0);

    // basic frame, bit_en every clk
    d0 = done_cnt;
    run_frame(1, 16, 4, 1, 16'h5555, 16'hFFFF, 0);
    finish_frame(d0, 1, 8'hAA);

    // bit_en every 4th clk, holding checked between strobes
    last_bit = 1'b0;
    hold_chk = 1'b1;
    d0 = done_cnt;
    run_frame(1, 16, 4, 4, 16'h5555, 16'hFFFF, 0);
    hold_chk = 1'b0;
    finish_frame(d0, 2, 8'hAA);

    // three underrun strobes in the payload
    d0 = done_cnt;
    run_frame(1, 8, 2, 1, 16'h00D3, 16'hFFE3, 0);
    finish_frame(d0, 3, 8'hC3);
    check("underrun_cnt", underrun_cnt, 3);

    // empty payload and gap
    d0 = done_cnt;
    run_frame(1, 0, 0, 1, 16'h0000, 16'hFFFF, 0);
    finish_frame(d0, 4, 8'h00);

    // payload shorter than the capture field, no gap
    d0 = done_cnt;
    run_frame(1, 3, 0, 1, 16'h0005, 16'hFFFF, 0);
    finish_frame(d0, 5, 8'hA0);
    check("underrun_hold", underrun_cnt, 3);

`ifdef FRAME_SCHED_AUTO_REPEAT_EN
    d0 = done_cnt;
    run_frame(1, 16, 4, 1, 16'h5555, 16'hFFFF, 0);
    check("repeat_first_phase", phase, 1);
    run_frame(0, 16, 4, 1, 16'h5555, 16'hFFFF, 0);
    repeat (2) @(posedge clk);
    #1;
    check("repeat_done_count", done_cnt, d0 + 2);
    check("repeat_frame_cnt", frame_cnt, 7);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("repeat_abort_phase", phase, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
